// File: rtl/soul_hit_detector_if.sv
// Pixel-side signals into the soul hit detector and its registered hit/HP outputs.
// master = game/video side, slave = the detector.
interface soul_hit_detector_if;
    logic [3:0] state;
    logic [9:0] x;
    logic [9:0] y;
    logic       bulletSpriteOn;
    logic       heartSpriteOn;
    logic       collision;
    logic [7:0] hp;
    logic       heartBlink;
    logic       gameOver;

    modport master (
        output state, x, y, bulletSpriteOn, heartSpriteOn,
        input  collision, hp, heartBlink, gameOver
    );

    modport slave (
        input  state, x, y, bulletSpriteOn, heartSpriteOn,
        output collision, hp, heartBlink, gameOver
    );
endinterface

// File: rtl/soul_hit_detector.sv
// Soul/bullet overlap detector: one hit decision per frame end, HP debit,
// invulnerability window with blink, and sticky game-over.
module soul_hit_detector #(
    parameter int HP_INIT       = 20,
    parameter int DAMAGE        = 4,
    parameter int INVULN_FRAMES = 30,
    parameter int FIGHT_STATE   = 1
) (
    input logic               clk,
    input logic               reset,
    soul_hit_detector_if.slave bus
);
    localparam logic [7:0] HP_RST = 8'(HP_INIT);
    localparam logic [7:0] DMG    = 8'(DAMAGE);
    localparam logic [7:0] INV    = 8'(INVULN_FRAMES);
    localparam logic [3:0] FIGHT  = 4'(FIGHT_STATE);

    typedef enum logic [1:0] {IDLE, ARMED, INVULN, DEAD} fsm_t;

    fsm_t       fsm, fsm_nxt;
    logic [7:0] icnt, icnt_nxt;
    logic [7:0] hp, hp_nxt;
    logic       ov, ov_nxt;
    logic       coll, coll_nxt;
    logic       blink, blink_nxt;
    logic       over, over_nxt;

    logic       fe, fight, hit_now, ov_any;
    logic [7:0] hp_debit;

    // HP never wraps below zero
    function automatic logic [7:0] sat_debit(input logic [7:0] v);
        return (v > DMG) ? v - DMG : 8'd0;
    endfunction

    assign fe       = (bus.x == 10'd639) && (bus.y == 10'd479);
    assign fight    = (bus.state == FIGHT);
    assign hit_now  = bus.bulletSpriteOn & bus.heartSpriteOn & fight;
    assign ov_any   = ov | hit_now;
    assign hp_debit = sat_debit(hp);

    always_comb begin
        fsm_nxt  = fsm;
        icnt_nxt = icnt;
        hp_nxt   = hp;
        coll_nxt = 1'b0;
        // overlap memory spans one frame and only while fighting
        ov_nxt   = fight & ~fe & ov_any;
        unique case (fsm)
            IDLE: begin
                if (fight) fsm_nxt = ARMED;
            end
            ARMED: begin
                if (!fight) begin
                    fsm_nxt  = IDLE;
                    icnt_nxt = 8'd0;
                end else if (fe && ov_any) begin
                    coll_nxt = 1'b1;
                    hp_nxt   = hp_debit;
                    if (hp_debit == 8'd0) begin
                        fsm_nxt = DEAD;
                    end else begin
                        fsm_nxt  = INVULN;
                        icnt_nxt = INV;
                    end
                end
            end
            INVULN: begin
                if (!fight) begin
                    fsm_nxt  = IDLE;
                    icnt_nxt = 8'd0;
                end else if (fe) begin
                    icnt_nxt = icnt - 8'd1;
                    if (icnt == 8'd1) fsm_nxt = ARMED;
                end
            end
            DEAD: begin
                fsm_nxt = DEAD;
            end
            default: fsm_nxt = IDLE;
        endcase
        blink_nxt = (fsm_nxt == INVULN) & icnt_nxt[1];
        over_nxt  = (fsm_nxt == DEAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm   <= IDLE;
            icnt  <= 8'd0;
            hp    <= HP_RST;
            ov    <= 1'b0;
            coll  <= 1'b0;
            blink <= 1'b0;
            over  <= 1'b0;
        end else begin
            fsm   <= fsm_nxt;
            icnt  <= icnt_nxt;
            hp    <= hp_nxt;
            ov    <= ov_nxt;
            coll  <= coll_nxt;
            blink <= blink_nxt;
            over  <= over_nxt;
        end
    end

    assign bus.collision  = coll;
    assign bus.hp         = hp;
    assign bus.heartBlink = blink;
    assign bus.gameOver   = over;
endmodule
